// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS fetch stage.
package mips_pkg;

  localparam int OPCODE_W = 6;
  localparam int INSTR_W  = 32;
  localparam logic [31:0] PC_INC = 32'd4;

  // Fetch FSM states; DROP waits out a fetch that a redirect made stale.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DROP  = 2'd2
  } fetch_state_e;

  // Force an address onto a word boundary.
  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/mips_pc_reg.sv
// Program counter register with next-PC select: hold, advance by one word,
// or load a word-aligned redirect target. Redirect wins over advance.
module mips_pc_reg
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inc,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] pc
);

  logic [31:0] pc_next;

  // Next-PC mux; the +4 wraps naturally modulo 2^32.
  always_comb begin
    pc_next = pc;
    if (redirect) begin
      pc_next = align_word(redirect_pc);
    end else if (inc) begin
      pc_next = pc + PC_INC;
    end
  end

  // PC register, asynchronously reset to the boot address.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc <= RESET_PC;
    end else begin
      pc <= pc_next;
    end
  end

endmodule

// File: rtl/mips_fetch_unit.sv
// Instruction-fetch stage: PC, req/ack fetch FSM and one-entry output
// register feeding the main decoder.
// Optional build macro MIPS_FETCH_PERF_EN adds FetchCount/FlushCount.
//
// Handshake: a fetch completes on any cycle where IMemReq and IMemAck are
// both high; IMemAddr is held stable while IMemReq waits for IMemAck. The
// output register is consumed on any cycle with InstrValid && !Stall.
module mips_fetch_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                CLK,
  input  logic                RST,
  output logic                IMemReq,
  output logic [31:0]         IMemAddr,
  input  logic                IMemAck,
  input  logic [31:0]         IMemRdata,
  input  logic                Stall,
  input  logic                Redirect,
  input  logic [31:0]         RedirectPC,
  output logic [INSTR_W-1:0]  Instr,
  output logic [31:0]         PCPlus4,
  output logic                InstrValid,
  output logic [OPCODE_W-1:0] Opcode
`ifdef MIPS_FETCH_PERF_EN
  ,
  output logic [31:0]         FetchCount,
  output logic [31:0]         FlushCount
`endif
);

  fetch_state_e state;
  fetch_state_e state_next;
  logic [31:0]  pc;
  logic [31:0]  drop_addr;
  logic         accept;
  logic         keep;
  logic         consume;

  // PC register with hold / +4 / redirect selection.
  mips_pc_reg #(
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk         (CLK),
    .rst         (RST),
    .inc         (keep),
    .redirect    (Redirect),
    .redirect_pc (RedirectPC),
    .pc          (pc)
  );

  // FSM next state and request decode.
  always_comb begin
    state_next = state;
    IMemReq    = 1'b0;
    unique case (state)
      IDLE: begin
        state_next = FETCH;
      end
      FETCH: begin
        IMemReq = !(InstrValid && Stall);
        if (Redirect && IMemReq && !IMemAck) begin
          state_next = DROP;
        end
      end
      DROP: begin
        IMemReq = 1'b1;
        if (IMemAck) begin
          state_next = FETCH;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // While dropping, keep presenting the stale address until it is acked.
  assign IMemAddr = (state == DROP) ? drop_addr : pc;
  assign accept   = (state == FETCH) && IMemReq && IMemAck;
  assign keep     = accept && !Redirect;
  assign consume  = InstrValid && !Stall;
  assign Opcode   = Instr[INSTR_W-1 -: OPCODE_W];

  // FSM state register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Remember the outstanding address when a redirect orphans it.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      drop_addr <= 32'h0;
    end else if ((state == FETCH) && (state_next == DROP)) begin
      drop_addr <= pc;
    end
  end

  // Output register: redirect flushes, accept fills, consume empties.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      Instr      <= '0;
      PCPlus4    <= 32'h0;
      InstrValid <= 1'b0;
    end else if (Redirect) begin
      InstrValid <= 1'b0;
    end else if (keep) begin
      Instr      <= IMemRdata;
      PCPlus4    <= pc + PC_INC;
      InstrValid <= 1'b1;
    end else if (consume) begin
      InstrValid <= 1'b0;
    end
  end

`ifdef MIPS_FETCH_PERF_EN
  // Performance counters: kept fetches and redirect cycles, free-running.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      FetchCount <= 32'h0;
      FlushCount <= 32'h0;
    end else begin
      if (keep) begin
        FetchCount <= FetchCount + 32'd1;
      end
      if (Redirect) begin
        FlushCount <= FlushCount + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_mips_fetch_unit.sv
// Bench for mips_fetch_unit: directed vectors, a cycle-level reference
// model of the fetch stage, an in-order scoreboard of delivered words and
// literal spot checks. A second instance boots at 32'hFFFF_FFFC.
module tb_mips_fetch_unit;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        req;
  logic [31:0] addr;
  logic        ack;
  logic [31:0] rdata;
  logic        stall;
  logic        redirect;
  logic [31:0] rpc;
  logic [31:0] instr;
  logic [31:0] pcp4;
  logic        valid;
  logic [5:0]  opcode;
  logic [31:0] key;
`ifdef MIPS_FETCH_PERF_EN
  logic [31:0] fetch_cnt;
  logic [31:0] flush_cnt;
`endif

  // Memory: word returned is its own address XOR a per-phase key.
  assign rdata = addr ^ key;

  mips_fetch_unit dut (
    .CLK        (clk),
    .RST        (rst),
    .IMemReq    (req),
    .IMemAddr   (addr),
    .IMemAck    (ack),
    .IMemRdata  (rdata),
    .Stall      (stall),
    .Redirect   (redirect),
    .RedirectPC (rpc),
    .Instr      (instr),
    .PCPlus4    (pcp4),
    .InstrValid (valid),
    .Opcode     (opcode)
`ifdef MIPS_FETCH_PERF_EN
    ,
    .FetchCount (fetch_cnt),
    .FlushCount (flush_cnt)
`endif
  );

  // Second instance: boot address at the top of memory, always acked.
  logic        rst2;
  logic        req2;
  logic [31:0] addr2;
  logic        ack2 = 1'b1;
  logic [31:0] rdata2;
  logic        stall2 = 1'b0;
  logic        redirect2 = 1'b0;
  logic [31:0] rpc2 = 32'h0;
  logic [31:0] instr2;
  logic [31:0] pcp4_2;
  logic        valid2;
  logic [5:0]  opcode2;
`ifdef MIPS_FETCH_PERF_EN
  logic [31:0] fetch_cnt2;
  logic [31:0] flush_cnt2;
`endif

  assign rdata2 = addr2;

  mips_fetch_unit #(
    .RESET_PC (32'hFFFF_FFFC)
  ) dut2 (
    .CLK        (clk),
    .RST        (rst2),
    .IMemReq    (req2),
    .IMemAddr   (addr2),
    .IMemAck    (ack2),
    .IMemRdata  (rdata2),
    .Stall      (stall2),
    .Redirect   (redirect2),
    .RedirectPC (rpc2),
    .Instr      (instr2),
    .PCPlus4    (pcp4_2),
    .InstrValid (valid2),
    .Opcode     (opcode2)
`ifdef MIPS_FETCH_PERF_EN
    ,
    .FetchCount (fetch_cnt2),
    .FlushCount (flush_cnt2)
`endif
  );

  // ---------------- checking ----------------
  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model of the fetch stage, in terms of what the stage is doing:
  // m_phase 0 = just out of reset, 1 = fetching, 2 = waiting out a stale fetch.
  int          m_phase;
  logic [31:0] m_pc;
  logic [31:0] m_old;
  logic [31:0] m_instr;
  logic [31:0] m_pcp4;
  logic        m_valid;
  logic [31:0] m_fetch;
  logic [31:0] m_flush;
  logic [31:0] exp_q[$];

  task automatic model_reset();
    m_phase = 0;
    m_pc    = 32'h0;
    m_old   = 32'h0;
    m_instr = 32'h0;
    m_pcp4  = 32'h0;
    m_valid = 1'b0;
    m_fetch = 32'h0;
    m_flush = 32'h0;
    exp_q.delete();
  endtask

  // One clock cycle: compare outputs against the model, then advance the
  // model with the inputs that were applied in this cycle.
  task automatic step();
    logic        e_req;
    logic [31:0] e_addr;
    logic [31:0] word;
    logic        took;
    #2;
    e_req  = (m_phase == 1) ? !(m_valid && stall) : (m_phase == 2);
    e_addr = (m_phase == 2) ? m_old : m_pc;
    chk("imem_req", req, e_req);
    if (e_req) chk("imem_addr", addr, e_addr);
    chk("instr_valid", valid, m_valid);
    chk("instr", instr, m_instr);
    chk("pc_plus4", pcp4, m_pcp4);
    chk("opcode", opcode, m_instr[31:26]);
`ifdef MIPS_FETCH_PERF_EN
    chk("fetch_count", fetch_cnt, m_fetch);
    chk("flush_count", flush_cnt, m_flush);
`endif
    if (m_valid && !stall && !redirect) begin
      if (exp_q.size() == 0) begin
        chk("sb_underflow", 32'd0, 32'd1);
      end else begin
        chk("sb_order", instr, exp_q.pop_front());
      end
    end
    word = e_addr ^ key;
    took = (m_phase == 1) && e_req && ack;
    @(posedge clk);
    if (redirect) begin
      m_flush = m_flush + 32'd1;
      if (m_phase == 1 && e_req && !ack) begin
        m_old   = m_pc;
        m_phase = 2;
      end else if (m_phase == 0 || (m_phase == 2 && ack)) begin
        m_phase = 1;
      end
      m_pc    = {rpc[31:2], 2'b00};
      m_valid = 1'b0;
      exp_q.delete();
    end else begin
      if (m_phase == 0 || (m_phase == 2 && ack)) m_phase = 1;
      if (took) begin
        m_instr = word;
        m_pcp4  = m_pc + 32'd4;
        m_valid = 1'b1;
        m_pc    = m_pc + 32'd4;
        m_fetch = m_fetch + 32'd1;
        exp_q.push_back(word);
      end else if (m_valid && !stall) begin
        m_valid = 1'b0;
      end
    end
    @(negedge clk);
  endtask

  // ---------------- driver ----------------
  task automatic drive(input logic s, input logic a, input logic r, input logic [31:0] t);
    stall    = s;
    ack      = a;
    redirect = r;
    rpc      = t;
    step();
  endtask

  // {stall, ack, redirect}
  logic [2:0] vecs [20] = '{3'b010, 3'b010, 3'b110, 3'b100, 3'b000,
                            3'b000, 3'b001, 3'b000, 3'b010, 3'b010,
                            3'b011, 3'b010, 3'b110, 3'b010, 3'b001,
                            3'b001, 3'b010, 3'b000, 3'b010, 3'b010};

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1; rst2 = 1'b1;
    stall = 1'b0; ack = 1'b0; redirect = 1'b0; rpc = 32'h0; key = 32'h0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_req", req, 32'd0);
    chk("rst_valid", valid, 32'd0);
    chk("rst_instr", instr, 32'd0);
    chk("rst_pcp4", pcp4, 32'd0);
    chk("rst_opcode", opcode, 32'd0);
    chk("rst2_addr", addr2, 32'hFFFF_FFFC);
`ifdef MIPS_FETCH_PERF_EN
    chk("rst_fetch_count", fetch_cnt, 32'd0);
    chk("rst_flush_count", flush_cnt, 32'd0);
`endif
    rst = 1'b0; rst2 = 1'b0;

    // Streaming: ack every cycle, word = address.
    drive(0, 1, 0, 0);                       // cycle 0 (idle)
    chk("wrap_req_c1", req2, 32'd1);
    chk("wrap_addr_c1", addr2, 32'hFFFF_FFFC);
    drive(0, 1, 0, 0);                       // cycle 1
    chk("wrap_addr_c2", addr2, 32'h0000_0000);
    chk("wrap_instr_c2", instr2, 32'hFFFF_FFFC);
    chk("wrap_pcp4_c2", pcp4_2, 32'h0000_0000);
    chk("wrap_valid_c2", valid2, 32'd1);
    drive(0, 1, 0, 0);                       // cycle 2
    chk("stream_instr_c3", instr, 32'h4);
    chk("stream_pcp4_c3", pcp4, 32'h8);
    chk("stream_addr_c3", addr, 32'h8);
    drive(0, 1, 0, 0);                       // cycle 3
    drive(0, 1, 0, 0);                       // cycle 4

    // Stall for three cycles while holding a valid instruction.
    repeat (3) drive(1, 1, 0, 0);            // cycles 5..7
    chk("stall_hold_instr", instr, 32'hC);
    chk("stall_resume_addr", addr, 32'h10);

    // Redirect while the fetch at 0x10 waits for its ack.
    drive(0, 0, 0, 0);                       // cycle 8
    drive(0, 0, 1, 32'h0000_0103);           // cycle 9
    chk("drop_old_addr", addr, 32'h10);
    chk("drop_req", req, 32'd1);
    drive(0, 0, 0, 0);                       // cycle 10
    drive(0, 1, 0, 0);                       // cycle 11, stale ack
    chk("drop_new_addr", addr, 32'h100);
    chk("drop_valid", valid, 32'd0);

    // Resume with a non-zero opcode in the fetched words.
    key = 32'hA400_0000;
    drive(0, 1, 0, 0);                       // cycle 12
    chk("opc_instr", instr, 32'hA400_0100);
    chk("opc_opcode", opcode, 32'h29);
    chk("opc_pcp4", pcp4, 32'h104);
    drive(0, 1, 0, 0);
    drive(0, 1, 0, 0);

    // Redirect together with ack and stall.
    drive(1, 1, 1, 32'h2000_0042);
    chk("rds_valid", valid, 32'd0);
    chk("rds_addr", addr, 32'h2000_0040);
    chk("rds_req", req, 32'd1);
    drive(0, 1, 0, 0);
    drive(0, 1, 0, 0);

    // Redirect together with an accepted ack: data discarded.
    drive(0, 1, 1, 32'h0000_0400);
    chk("rda_valid", valid, 32'd0);
    chk("rda_addr", addr, 32'h400);
    drive(0, 1, 0, 0);
    drive(0, 1, 0, 0);

    // Mixed directed vectors.
    key = 32'h8C00_0000;
    for (int i = 0; i < 20; i++) begin
      logic s, a, r;
      {s, a, r} = vecs[i];
      if (m_phase == 2 && r) a = 1'b0;
      drive(s, a, r, $urandom_range(0, 32'h0000_FFFF));
    end

    // Reset pulsed while a request is outstanding.
    drive(0, 0, 0, 0);
    ack = 1'b0; stall = 1'b0; redirect = 1'b0;
    #2;
    chk("pre_rst_req", req, 32'd1);
    rst = 1'b1;
    #1;
    chk("async_rst_req", req, 32'd0);
    chk("async_rst_valid", valid, 32'd0);
    chk("async_rst_instr", instr, 32'd0);
`ifdef MIPS_FETCH_PERF_EN
    chk("async_rst_fetch_count", fetch_cnt, 32'd0);
    chk("async_rst_flush_count", flush_cnt, 32'd0);
`endif
    model_reset();
    key = 32'h0;
    @(negedge clk);
    rst = 1'b0;
    drive(0, 1, 0, 0);
    drive(0, 1, 0, 0);
    drive(0, 1, 0, 0);
    chk("restart_instr", instr, 32'h4);
    drive(0, 1, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mips_fetch_unit.md
# mips_fetch_unit

Instruction-fetch stage of the MIPS core, directly upstream of `MIPS_MainDecoder`. It holds the program counter and fetches instruction words from instruction memory over a req/ack handshake. It presents each word, with its PC+4, in a one-entry output register whose `Opcode` field drives the main decoder. It accepts branch/jump redirects from later stages and flushes any in-flight fetch.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC loaded on reset.
- `CLK`  in  1: single clock, rising edge.
- `RST`  in  1: asynchronous, active-high reset.
- `IMemReq`  out  1: fetch request to instruction memory.
- `IMemAddr`  out  32: word-aligned fetch address, equal to the PC.
- `IMemAck`  in  1: memory returns `IMemRdata` this cycle; may be asserted in the same cycle as `IMemReq`.
- `IMemRdata`  in  32: instruction word.
- `Stall`  in  1: decode cannot consume the output register this cycle.
- `Redirect`  in  1: taken branch/jump; flush and refetch.
- `RedirectPC`  in  32: redirect target; bits [1:0] are ignored and forced to 0.
- `Instr`  out  32: registered instruction.
- `PCPlus4`  out  32: registered PC of `Instr` + 4.
- `InstrValid`  out  1: `Instr`/`PCPlus4` hold a live instruction.
- `Opcode`  out  6: `Instr[31:26]`, feeds `MIPS_MainDecoder`.

## Operation
- FSM states: IDLE, FETCH, DROP.
  - IDLE: reset state; `IMemReq`=0; always moves to FETCH on the next edge.
  - FETCH: `IMemReq` = !(`InstrValid` && `Stall`); `IMemAddr` = PC.
  - DROP: a redirect arrived while a request was outstanding. `IMemReq`=1 at the old address until `IMemAck`; the returned data is discarded; then go to FETCH at the new PC.
- Consume: an instruction is consumed when `InstrValid` && !`Stall`.
- Accept: `IMemAck` while `IMemReq`=1 in FETCH. On accept:
  - `Instr`←`IMemRdata`, `PCPlus4`←PC+4, `InstrValid`←1, PC←PC+4.
  - If there is no accept and the instruction is consumed, `InstrValid`←0.
- The output register fills only on accept, so a request asserted without ack stays asserted. `IMemAddr` is stable from assertion until ack.
- Redirect has priority over accept, consume and `Stall`:
  - Next edge: `InstrValid`←0 and PC←{`RedirectPC`[31:2],2'b00}.
  - Request outstanding with no ack this cycle → DROP.
  - Ack in the same cycle → data discarded; stay in FETCH.
  - Redirect while in DROP → update PC, remain in DROP.
- PC arithmetic is modulo 2^32: 32'hFFFF_FFFC + 4 wraps to 0.

## Timing
- Reset values: PC=`RESET_PC`, `Instr`=0, `PCPlus4`=0, `InstrValid`=0, `Opcode`=0, `IMemReq`=0, state=IDLE.
- Because `IMemReq` is decoded from state, it falls asynchronously when `RST` asserts mid-request.
- First `IMemReq` appears in the second cycle after `RST` deasserts.
- Latency: ack in cycle N → `InstrValid`/`Instr` visible in cycle N+1.
- Throughput: one instruction per cycle with single-cycle ack and no stall.
- Redirect asserted in cycle N:
  - `InstrValid`=0 in N+1.
  - First request to the new PC in N+1 (FETCH case), or the cycle after the dropped ack (DROP case).

## Configuration
- `MIPS_FETCH_PERF_EN` defined: adds outputs `FetchCount` (32-bit) and `FlushCount` (32-bit).
  - `FetchCount` increments on every accept that is not discarded.
  - `FlushCount` increments on every cycle with `Redirect`=1.
  - Both reset to 0 and wrap.
- Undefined: both ports and both counters are absent; all other behaviour is identical.

## Structure
- `mips_pkg`: FSM state enum (IDLE/FETCH/DROP), `OPCODE_W`=6, `INSTR_W`=32, `PC_INC`=4.
- Sub-module `mips_pc_reg`: the PC register plus next-PC mux (hold / +4 / redirect), with asynchronous reset to `RESET_PC`.
- The FSM and output register stay in `mips_fetch_unit`.

## Test plan
- Reset release, memory acks every cycle with word = address:
  - `IMemAddr` is 0, 4, 8…
  - `Instr` is 0, 4, 8… on consecutive cycles from cycle 2 after reset.
- `Stall` held for 3 cycles with `InstrValid`=1:
  - `IMemReq`=0 and `Instr` unchanged during the stall.
  - Fetching resumes the cycle `Stall` drops; no word is lost or duplicated.
- `Redirect` to 32'h0000_0103 while a request at 0x10 waits 2 cycles for ack:
  - DROP state; the 0x10 data is discarded.
  - Next request is at 0x100.
- `Redirect` coincident with `IMemAck` and `Stall`=1: `InstrValid`=0 next cycle; next `IMemAddr` is the target.
- `RESET_PC`=32'hFFFF_FFFC: second fetch address is 0 (wrap), `PCPlus4`=0.
- `RST` pulsed mid-request: `IMemReq` drops the same cycle; `InstrValid`=0; with `MIPS_FETCH_PERF_EN`, both counters read 0.
